// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder: decode stage that latches a fetched opcode into ir via a valid/ready handshake, decodes it into datapath selects and register enables, stalls on reads of a pending ALU result, and freezes register writes inside a pc window.
// Ports: clk, sync_reset_n (sync, active-low); next_instr/next_valid/id_ready fetch handshake; pc of the instruction in ir;
// ir, ir_nibble, jmp, jmp_nz, i_sel, x_sel, y_sel, source_sel, reg_en ([0]x0 [1]x1 [2]y0 [3]y1 [4]r [5]m [6]i [7]dm [8]o_reg), stall, from_ID debug tap.
// Optional feature macro: DECODE_TRACE_EN (from_ID shows the issuing opcode, 8'hFF while stalled).
module pipelined_instruction_decoder #(
  parameter int PC_W = 8,
  parameter int ALU_LAT = 1,
  parameter logic [PC_W-1:0] FREEZE_LO = 'h04,
  parameter logic [PC_W-1:0] FREEZE_HI = 'h0A
) (
  input  logic            clk,
  input  logic            sync_reset_n,
  input  logic [7:0]      next_instr,
  input  logic            next_valid,
  output logic            id_ready,
  input  logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic            jmp,
  output logic            jmp_nz,
  output logic [3:0]      ir_nibble,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            stall,
  output logic [7:0]      from_ID
);
  logic [7:0] ir_q, ir_d;
  logic       ir_valid_q, ir_valid_d;
  logic [1:0] pend_q, pend_d;
  logic       is_load, is_move, is_alu, is_jmp, is_jnz, issue, frozen;
  logic [2:0] ld_dst, mv_dst, mv_src;
  logic [8:0] load_en, move_en, dec_en;
  function automatic logic [8:0] dmask(input logic [2:0] d);
    return d == 3'd4 ? 9'h100 : 9'd1 << d;
  endfunction
  assign is_load = ~ir_q[7];
  assign is_move = ir_q[7:6] == 2'b10;
  assign is_alu  = ir_q[7:5] == 3'b110;
  assign is_jmp  = ir_q[7:4] == 4'b1110;
  assign is_jnz  = ir_q[7:4] == 4'b1111;
  assign ld_dst  = ir_q[6:4];
  assign mv_dst  = ir_q[5:3];
  assign mv_src  = ir_q[2:0];
  // src==4 reads r, which is only safe once the ALU countdown has drained
  assign stall    = sync_reset_n & ir_valid_q & (pend_q != 2'd0) &
                    (is_jnz | (is_move & mv_src == 3'd4 & mv_dst != 3'd4));
  assign id_ready = sync_reset_n & ~stall;
  assign issue    = sync_reset_n & ir_valid_q & ~stall;
  assign frozen   = pc >= FREEZE_LO && pc <= FREEZE_HI;
  assign load_en  = ld_dst == 3'd7 ? 9'h0C0 : dmask(ld_dst);
  // writes to dm or reads from dm also step the i pointer (bit 6)
  assign move_en  = (mv_dst == 3'd4 && mv_src == 3'd6) ? 9'h100 :
                    (mv_dst == 3'd7 || (mv_src == 3'd7 && mv_dst != 3'd6)) ? dmask(mv_dst) | 9'h040 :
                    dmask(mv_dst);
  assign dec_en   = is_load ? load_en : is_move ? move_en : is_alu ? 9'h010 : 9'h000;
  always_comb begin
    ir_d       = id_ready ? next_instr : ir_q;
    ir_valid_d = id_ready ? next_valid : ir_valid_q;
    pend_d     = (issue && is_alu) ? 2'(ALU_LAT - 1) : (pend_q != 2'd0) ? pend_q - 2'd1 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      ir_q       <= 8'h00;
      ir_valid_q <= 1'b0;
      pend_q     <= 2'd0;
    end else begin
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pend_q     <= pend_d;
    end
  end
  always_comb begin
    ir         = ir_q;
    ir_nibble  = ir_q[3:0];
    jmp        = issue & is_jmp;
    jmp_nz     = issue & is_jnz;
    x_sel      = issue & ir_q[4];
    y_sel      = issue & ir_q[3];
    reg_en     = !sync_reset_n ? 9'h1FF : (issue && !frozen) ? dec_en : 9'h000;
    source_sel = !sync_reset_n ? 4'd10 : !(issue && is_move) ? 4'd8 :
                 mv_src == mv_dst ? 4'd9 : {1'b0, mv_src};
    i_sel      = !sync_reset_n ? 1'b0 : !issue ? 1'b1 :
                 ~((is_load && ld_dst == 3'd6) || (is_move && mv_dst == 3'd6));
`ifdef DECODE_TRACE_EN
    from_ID    = issue ? ir_q : stall ? 8'hFF : 8'h00;
`else
    from_ID    = 8'h00;
`endif
  end
endmodule
